// File: rtl/wb_ram_bus_mux_n_if.sv
// Bus bundle between the Caravel management Wishbone (UFP) and N downstream RAM-style slaves (DFP).
// Latency: none, wires only.
// Backpressure: carried by the Wishbone ack signals; the router holds one access at a time.
interface wb_ram_bus_mux_n_if #(
    parameter int N_PORTS = 3
);
    // Upstream-facing port (router is the Wishbone slave here)
    logic                    wbs_ufp_stb_i;
    logic                    wbs_ufp_cyc_i;
    logic                    wbs_ufp_we_i;
    logic [3:0]              wbs_ufp_sel_i;
    logic [31:0]             wbs_ufp_adr_i;
    logic [31:0]             wbs_ufp_dat_i;
    logic                    wbs_ufp_ack_o;
    logic [31:0]             wbs_ufp_dat_o;

    // Downstream-facing ports (router is the Wishbone master here)
    logic [N_PORTS-1:0]      wbs_dfp_stb_o;
    logic [N_PORTS-1:0]      wbs_dfp_cyc_o;
    logic                    wbs_dfp_we_o;
    logic [3:0]              wbs_dfp_sel_o;
    logic [31:0]             wbs_dfp_adr_o;
    logic [31:0]             wbs_dfp_dat_o;
    logic [32*N_PORTS-1:0]   wbs_dfp_dat_i;
    logic [N_PORTS-1:0]      wbs_dfp_ack_i;

    // View taken by the router
    modport slave (
        input  wbs_ufp_stb_i, wbs_ufp_cyc_i, wbs_ufp_we_i, wbs_ufp_sel_i,
        input  wbs_ufp_adr_i, wbs_ufp_dat_i,
        output wbs_ufp_ack_o, wbs_ufp_dat_o,
        output wbs_dfp_stb_o, wbs_dfp_cyc_o, wbs_dfp_we_o, wbs_dfp_sel_o,
        output wbs_dfp_adr_o, wbs_dfp_dat_o,
        input  wbs_dfp_dat_i, wbs_dfp_ack_i
    );

    // View taken by the surrounding environment (management core plus downstream slaves)
    modport master (
        output wbs_ufp_stb_i, wbs_ufp_cyc_i, wbs_ufp_we_i, wbs_ufp_sel_i,
        output wbs_ufp_adr_i, wbs_ufp_dat_i,
        input  wbs_ufp_ack_o, wbs_ufp_dat_o,
        input  wbs_dfp_stb_o, wbs_dfp_cyc_o, wbs_dfp_we_o, wbs_dfp_sel_o,
        input  wbs_dfp_adr_o, wbs_dfp_dat_o,
        output wbs_dfp_dat_i, wbs_dfp_ack_i
    );
endinterface

// File: rtl/wb_ram_bus_mux_n.sv
// N-port Wishbone router: decodes the UFP address onto one of N_PORTS downstream ports, with decode-error, timeout and abort.
// Latency: ufp ack in the cycle after the downstream ack edge (min 2 cycles); decode error 2 cycles; timeout TIMEOUT_CYCLES+1.
// Backpressure: one access outstanding; new UFP requests are only sampled in IDLE, so the master waits for ack.
module wb_ram_bus_mux_n #(
    parameter int          N_PORTS        = 3,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0] BASE_MASK      = 32'hFF00_0000,
    parameter int          SEL_LSB        = 20,
    parameter int          SEL_W          = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_ram_bus_mux_n_if.slave    bus,
    output logic                 dec_err_o,
    output logic                 timeout_o,
    output logic [SEL_W-1:0]     active_port_o
);

    localparam int             CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [SEL_W:0] IDX_LIMIT = (SEL_W+1)'(N_PORTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                ufp_ack_q;
    logic [31:0]         ufp_dat_q;
    logic [N_PORTS-1:0]  dfp_cyc_q;
    logic [N_PORTS-1:0]  dfp_stb_q;
    logic                dfp_we_q;
    logic [3:0]          dfp_sel_q;
    logic [31:0]         dfp_adr_q;
    logic [31:0]         dfp_dat_q;
    logic                dec_err_q;
    logic                timeout_q;
    logic [SEL_W-1:0]    port_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                req_vld;
    logic                req_mapped;
    logic [SEL_W-1:0]    req_idx;
    logic [N_PORTS-1:0]  req_onehot;
    logic                sel_ack_d;
    logic [31:0]         sel_dat_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                cnt_expired;

    // Address decode of the incoming UFP request
    always_comb begin
        req_vld    = bus.wbs_ufp_cyc_i & bus.wbs_ufp_stb_i;
        req_idx    = bus.wbs_ufp_adr_i[SEL_LSB +: SEL_W];
        req_mapped = ((bus.wbs_ufp_adr_i & BASE_MASK) == (BASE_ADDR & BASE_MASK))
                     && ({1'b0, req_idx} < IDX_LIMIT);
        req_onehot = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            req_onehot[p] = (req_idx == SEL_W'(p));
        end
    end

    // Only the port that owns the access may complete it; everything else is ignored
    always_comb begin
        sel_ack_d = 1'b0;
        sel_dat_d = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (port_q == SEL_W'(p)) begin
                sel_ack_d = bus.wbs_dfp_ack_i[p];
                sel_dat_d = bus.wbs_dfp_dat_i[32*p +: 32];
            end
        end
        cnt_d       = cnt_q + CNT_W'(1);
        cnt_expired = (cnt_q == CNT_LAST);
    end

    // Transaction FSM; every output is a register written here
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            ufp_ack_q <= 1'b0;
            ufp_dat_q <= '0;
            dfp_cyc_q <= '0;
            dfp_stb_q <= '0;
            dfp_we_q  <= 1'b0;
            dfp_sel_q <= '0;
            dfp_adr_q <= '0;
            dfp_dat_q <= '0;
            dec_err_q <= 1'b0;
            timeout_q <= 1'b0;
            port_q    <= '0;
            cnt_q     <= '0;
        end else begin
            dec_err_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_vld) begin
                        if (req_mapped) begin
                            dfp_we_q  <= bus.wbs_ufp_we_i;
                            dfp_sel_q <= bus.wbs_ufp_sel_i;
                            dfp_adr_q <= bus.wbs_ufp_adr_i;
                            dfp_dat_q <= bus.wbs_ufp_dat_i;
                            dfp_cyc_q <= req_onehot;
                            dfp_stb_q <= req_onehot;
                            port_q    <= req_idx;
                            cnt_q     <= '0;
                            state_q   <= S_BUSY;
                        end else begin
                            // Unmapped: answer locally, downstream never sees it
                            ufp_dat_q <= ERR_DATA;
                            dec_err_q <= 1'b1;
                            state_q   <= S_RESP;
                        end
                    end
                end
                S_BUSY: begin
                    if (!bus.wbs_ufp_cyc_i) begin
                        // Master gave up: release downstream silently
                        dfp_cyc_q <= '0;
                        dfp_stb_q <= '0;
                        state_q   <= S_IDLE;
                    end else if (sel_ack_d) begin
                        // A real ack beats a timeout landing on the same edge
                        ufp_dat_q <= sel_dat_d;
                        ufp_ack_q <= 1'b1;
                        dfp_cyc_q <= '0;
                        dfp_stb_q <= '0;
                        state_q   <= S_RESP;
                    end else if (cnt_expired) begin
                        ufp_dat_q <= ERR_DATA;
                        ufp_ack_q <= 1'b1;
                        timeout_q <= 1'b1;
                        dfp_cyc_q <= '0;
                        dfp_stb_q <= '0;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    // Downstream completions arrive with ack already set; a decode
                    // error arrives without it and raises it here one cycle later
                    if (ufp_ack_q) begin
                        ufp_ack_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        ufp_ack_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wbs_ufp_ack_o = ufp_ack_q;
    assign bus.wbs_ufp_dat_o = ufp_dat_q;
    assign bus.wbs_dfp_cyc_o = dfp_cyc_q;
    assign bus.wbs_dfp_stb_o = dfp_stb_q;
    assign bus.wbs_dfp_we_o  = dfp_we_q;
    assign bus.wbs_dfp_sel_o = dfp_sel_q;
    assign bus.wbs_dfp_adr_o = dfp_adr_q;
    assign bus.wbs_dfp_dat_o = dfp_dat_q;
    assign dec_err_o         = dec_err_q;
    assign timeout_o         = timeout_q;
    assign active_port_o     = port_q;

endmodule

// File: doc/wb_ram_bus_mux_n.md
Name: wb_ram_bus_mux_n

Overview:
- Parametrised N-port Wishbone slave-side router in the user project area. Successor to the fixed two-port HyperRAM/OpenRAM mux.
- One upstream-facing port (UFP) from the Caravel management Wishbone. It fans out to N_PORTS downstream-facing ports (DFP), selected by an address field.
- Additions over the two-port mux: registered request path, decode-error response for unmapped addresses, per-transaction timeout watchdog, and abort on cyc drop.
- Status pulses are intended for user_irq.

Parameters:
- N_PORTS, 3, number of downstream ports (1..8).
- BASE_ADDR, 32'h3000_0000, address region claimed by the mux.
- BASE_MASK, 32'hFF00_0000, bits of the address compared against BASE_ADDR.
- SEL_LSB, 20, lowest address bit of the port-select field.
- SEL_W, 2, width of the port-select field; 2**SEL_W >= N_PORTS.
- TIMEOUT_CYCLES, 255, cycles waited for a downstream ack before forced completion (>=2).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on decode error or timeout.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_ufp_stb_i  in  1  UFP strobe
- wbs_ufp_cyc_i  in  1  UFP cycle
- wbs_ufp_we_i  in  1  UFP write enable
- wbs_ufp_sel_i  in  4  UFP byte selects
- wbs_ufp_adr_i  in  32  UFP address
- wbs_ufp_dat_i  in  32  UFP write data
- wbs_ufp_ack_o  out  1  UFP ack, registered
- wbs_ufp_dat_o  out  32  UFP read data, registered
- wbs_dfp_stb_o  out  N_PORTS  per-port strobe
- wbs_dfp_cyc_o  out  N_PORTS  per-port cycle
- wbs_dfp_we_o  out  1  shared write enable
- wbs_dfp_sel_o  out  4  shared byte selects
- wbs_dfp_adr_o  out  32  shared address
- wbs_dfp_dat_o  out  32  shared write data
- wbs_dfp_dat_i  in  32*N_PORTS  per-port read data; port p occupies [32p+31:32p]
- wbs_dfp_ack_i  in  N_PORTS  per-port ack
- dec_err_o  out  1  one-cycle pulse on decode error
- timeout_o  out  1  one-cycle pulse on timeout
- active_port_o  out  SEL_W  index of the last selected port

Behaviour:
- Reset value of every output is 0; the FSM goes to IDLE and the timeout counter clears. Reset asserted mid-transaction takes effect at the next edge, with no ack issued.
- Decode: the access is mapped when (adr & BASE_MASK) == (BASE_ADDR & BASE_MASK) and idx = adr[SEL_LSB +: SEL_W] < N_PORTS.
- FSM states: IDLE, BUSY, RESP.
- IDLE, entry condition: ufp cyc & stb are sampled high.
- IDLE, mapped access:
  - register we/sel/adr/dat onto the shared DFP buses;
  - set dfp_cyc[idx] and dfp_stb[idx];
  - set active_port_o = idx;
  - clear the counter;
  - go to BUSY.
- IDLE, unmapped access: load ufp_dat_o = ERR_DATA, pulse dec_err_o, go to RESP. No DFP activity occurs.
- BUSY, completion: on an edge where dfp_ack_i[idx] = 1:
  - capture that port's dat_i into ufp_dat_o (writes also capture it; the value is don't-care);
  - clear dfp cyc/stb;
  - go to RESP.
- BUSY, ignored inputs: acks and data from non-selected ports are ignored.
- BUSY, timeout: if the counter reaches TIMEOUT_CYCLES-1 with no ack, clear dfp cyc/stb, load ERR_DATA, pulse timeout_o, go to RESP. An ack arriving on the same edge wins, and no timeout is flagged.
- BUSY, abort: if ufp cyc goes low in BUSY, clear dfp cyc/stb and return to IDLE. No ufp ack is issued and no flags are raised.
- RESP: ufp_ack_o = 1 for exactly one cycle, then go to IDLE. A new request is accepted no earlier than the cycle after ack.
- Latency, mapped access: request sampled at edge 0; dfp stb high from edge 0. A downstream ack at edge k gives ufp ack high for the cycle after edge k. The minimum is ufp ack in the cycle after edge 1 (k = 1).
- Latency, decode error: ufp ack in the cycle after edge 1.
- Latency, timeout: ufp ack in the cycle after edge TIMEOUT_CYCLES.
- At most one DFP cyc bit is high at any time. Verification asserts one-hot-or-zero.
- Pipelined Wishbone is not supported: the mux does not accept a new request while not in IDLE.

Test Plan:
- Read from 0x3000_0004 (port 0), port 0 acks one cycle after stb with 0x1234_5678 -> only dfp_cyc[0] asserted; ufp ack single-cycle; ufp_dat_o = 0x1234_5678; active_port_o = 0.
- Write 0xA5A5_0001, sel = 4'b0011, to 0x3020_0010 (port 2) -> dfp_adr_o = 0x3020_0010, dfp_sel_o = 0011, dfp_dat_o = 0xA5A5_0001, dfp_we_o = 1, only dfp_stb[2] high; one ufp ack.
- Read from 0x3030_0000 (idx 3 >= N_PORTS), then from 0x4000_0000 -> each returns ERR_DATA with a dec_err_o pulse and no DFP cyc; ack in the cycle after edge 1.
- Port 1 never acks, TIMEOUT_CYCLES = 255 -> dfp_cyc[1] drops at edge 255; timeout_o pulse; ufp ack with 0xDEAD_BEEF. Repeat with the ack landing exactly on edge 255 -> normal data returned, no timeout_o.
- Abort and reset:
  - Drop ufp cyc two cycles into BUSY, then a late port ack arrives -> DFP cleared next edge; no ufp ack; the late ack is ignored.
  - Assert wb_rst_i during BUSY -> all outputs 0 next edge.
- Back-to-back reads to ports 0, 1, 2 with random ack delays 1..10 -> each returns the correct per-port data; the one-hot-or-zero assertion holds throughout.
